// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: CPU instruction/data buses, block RAM port and status flags of the responder
interface cpu_mem_responder_if #(parameter int ADDR_BITS = 14);
  logic                 cpud_request;
  logic [31:0]          cpud_addr;
  logic                 cpud_write;
  logic [3:0]           cpud_byte_enable;
  logic [31:0]          cpud_wdata;
  logic [31:0]          cpud_rdata;
  logic                 cpud_ack;
  logic                 cpui_request;
  logic [31:0]          cpui_addr;
  logic [31:0]          cpui_rdata;
  logic                 cpui_ack;
  logic                 ram_en;
  logic [3:0]           ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata;
  logic                 decode_err;
  logic                 overrun;
  modport slave (
    input  cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata,
    input  cpui_request, cpui_addr, ram_rdata,
    output cpud_rdata, cpud_ack, cpui_rdata, cpui_ack,
    output ram_en, ram_we, ram_addr, ram_wdata, decode_err, overrun
  );
  modport master (
    output cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata,
    output cpui_request, cpui_addr, ram_rdata,
    input  cpud_rdata, cpud_ack, cpui_rdata, cpui_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata, decode_err, overrun
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: arbitrates CPU data/instruction request pulses onto one synchronous RAM port and returns ack pulses
module cpu_mem_responder #(
  parameter int ADDR_BITS   = 14,
  parameter int WAIT_STATES = 0
) (
  input logic               clock,
  input logic               reset,
  cpu_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  state_t state_q, state_d;
  logic d_busy_q, d_busy_d, i_busy_q, i_busy_d, d_pend_q, d_pend_d, i_pend_q, i_pend_d;
  logic [31:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d, i_addr_q, i_addr_d;
  logic d_we_q, d_we_d;
  logic [3:0] d_be_q, d_be_d;
  logic cur_d_q, cur_d_d, cur_we_q, cur_we_d, cur_err_q, cur_err_d;
  logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
  logic [31:0] cur_wdata_q, cur_wdata_d, rd_q, rdata_v;
  logic [3:0] cur_be_q, cur_be_d;
  logic [2:0] cnt_q, cnt_d;
  logic after_acc_q, overrun_q, overrun_d;
  logic resp, arb, d_acc, i_acc, gnt_d, gnt_i, gnt, wr_en;
  logic [31:0] ed_addr, ed_wdata, ei_addr, sel_addr;
  logic ed_we;
  logic [3:0] ed_be;
  logic unused;
  assign unused = ^sel_addr[1:0];
  always_comb begin
    resp = state_q == RESP;
    arb = state_q == IDLE || resp;
    // a bus may re-request in its own ack cycle: its slot frees at that edge
    d_acc = bus.cpud_request && (!d_busy_q || (resp && cur_d_q));
    i_acc = bus.cpui_request && (!i_busy_q || (resp && !cur_d_q));
    gnt_d = arb && (d_pend_q || d_acc);
    gnt_i = arb && !gnt_d && (i_pend_q || i_acc);
    gnt = gnt_d || gnt_i;
    ed_addr = d_pend_q ? d_addr_q : bus.cpud_addr;
    ed_we = d_pend_q ? d_we_q : bus.cpud_write;
    ed_be = d_pend_q ? d_be_q : bus.cpud_byte_enable;
    ed_wdata = d_pend_q ? d_wdata_q : bus.cpud_wdata;
    ei_addr = i_pend_q ? i_addr_q : bus.cpui_addr;
    sel_addr = gnt_d ? ed_addr : ei_addr;
    d_addr_d = d_acc ? bus.cpud_addr : d_addr_q;
    d_we_d = d_acc ? bus.cpud_write : d_we_q;
    d_be_d = d_acc ? bus.cpud_byte_enable : d_be_q;
    d_wdata_d = d_acc ? bus.cpud_wdata : d_wdata_q;
    i_addr_d = i_acc ? bus.cpui_addr : i_addr_q;
    d_pend_d = !gnt_d && (d_pend_q || d_acc);
    i_pend_d = !gnt_i && (i_pend_q || i_acc);
    d_busy_d = d_acc || (d_busy_q && !(resp && cur_d_q));
    i_busy_d = i_acc || (i_busy_q && !(resp && !cur_d_q));
    overrun_d = overrun_q || (bus.cpud_request && !d_acc) || (bus.cpui_request && !i_acc);
    cur_d_d = gnt ? gnt_d : cur_d_q;
    cur_addr_d = gnt ? sel_addr[ADDR_BITS+1:2] : cur_addr_q;
    cur_err_d = gnt ? |sel_addr[31:ADDR_BITS+2] : cur_err_q;
    cur_we_d = gnt ? gnt_d && ed_we : cur_we_q;
    cur_be_d = gnt_d ? ed_be : cur_be_q;
    cur_wdata_d = gnt_d ? ed_wdata : cur_wdata_q;
    state_d = arb ? (gnt ? ACCESS : IDLE)
            : state_q == ACCESS ? (WAIT_STATES == 0 ? RESP : WAIT)
            : (cnt_q == 3'd0 ? RESP : WAIT);
    cnt_d = state_q == ACCESS ? WAIT_LOAD : cnt_q - 3'd1;
    bus.ram_en = state_q == ACCESS && !cur_err_q;
    wr_en = bus.ram_en && cur_we_q;
    bus.ram_we = wr_en ? cur_be_q : 4'h0;
    bus.ram_wdata = wr_en ? cur_wdata_q : 32'h0;
    bus.ram_addr = state_q == ACCESS ? cur_addr_q : '0;
    rdata_v = (cur_we_q || cur_err_q) ? 32'h0 : (after_acc_q ? bus.ram_rdata : rd_q);
    bus.cpud_ack = resp && cur_d_q;
    bus.cpui_ack = resp && !cur_d_q;
    bus.cpud_rdata = bus.cpud_ack ? rdata_v : 32'h0;
    bus.cpui_rdata = bus.cpui_ack ? rdata_v : 32'h0;
    bus.decode_err = resp && cur_err_q;
    bus.overrun = overrun_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      {d_busy_q, i_busy_q, d_pend_q, i_pend_q, d_we_q, overrun_q, after_acc_q} <= '0;
      {d_addr_q, d_wdata_q, i_addr_q, d_be_q} <= '0;
      {cur_d_q, cur_we_q, cur_err_q, cur_addr_q, cur_wdata_q, cur_be_q, cnt_q, rd_q} <= '0;
    end else begin
      state_q <= state_d;
      {d_busy_q, i_busy_q, d_pend_q, i_pend_q, d_we_q, overrun_q} <= {d_busy_d, i_busy_d, d_pend_d, i_pend_d, d_we_d, overrun_d};
      {d_addr_q, d_wdata_q, i_addr_q, d_be_q} <= {d_addr_d, d_wdata_d, i_addr_d, d_be_d};
      {cur_d_q, cur_we_q, cur_err_q, cur_addr_q, cur_wdata_q, cur_be_q, cnt_q} <= {cur_d_d, cur_we_d, cur_err_d, cur_addr_d, cur_wdata_d, cur_be_d, cnt_d};
      after_acc_q <= state_q == ACCESS;
      rd_q <= after_acc_q ? bus.ram_rdata : rd_q;
    end
  end
endmodule
